// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the branch predictor.
// Latency: n/a (package). Backpressure: n/a.
package bp_pkg;
  // Upper bound on XLEN; BTB fields are stored zero-extended to this width.
  localparam int BP_XLEN_MAX = 32;

  typedef struct packed {
    logic                   valid;
    logic [BP_XLEN_MAX-1:0] tag;
    logic [BP_XLEN_MAX-1:0] target;
    logic                   is_jmp;
  } btb_entry_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input int width);
    logic [3:0] max_v;
    max_v = 4'((1 << width) - 1);
    return (cnt == max_v) ? cnt : cnt + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] cnt, input int width);
    return (cnt == 4'd0) ? cnt : cnt - 4'd1;
  endfunction

  // Weakly-not-taken: 2^(width-1)-1, which is 0 for a 1-bit counter.
  function automatic logic [3:0] cnt_init(input int width);
    return 4'((1 << (width - 1)) - 1);
  endfunction
endpackage

// File: rtl/bht_table.sv
// Saturating-counter pattern table: async read, read-modify-write training port.
// Latency: read 0 cycles, write at next clock edge. Backpressure: none, accepts one write per cycle.
module bht_table
  import bp_pkg::*;
#(
  parameter int  ENTRIES = 256,
  parameter int  CNT_W   = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0] o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);
  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] cnt_d [ENTRIES];
  logic [3:0]       cur_cnt;

  always_comb begin
    cnt_d   = cnt_q;
    cur_cnt = 4'(cnt_q[i_wr_idx]);
    if (i_wr_en) begin
      cnt_d[i_wr_idx] = CNT_W'(i_wr_taken ? sat_inc(cur_cnt, CNT_W) : sat_dec(cur_cnt, CNT_W));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_W'(cnt_init(CNT_W));
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_rd_cnt = cnt_q[i_rd_idx];
endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus bimodal/gshare BHT, trained at resolution.
// Latency: lookup and mispredict 0 cycles, training at next edge. Backpressure: none, one update per cycle.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int  XLEN        = 32,
  parameter int  BTB_ENTRIES = 64,
  parameter int  BHT_ENTRIES = 256,
  parameter int  CNT_W       = 2,
  parameter int  GHR_W       = 0,
  localparam int BIDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [XLEN-1:0]   i_pc_if,
  output logic              o_pred_taken,
  output logic [XLEN-1:0]   o_pred_target,
  output logic              o_pred_hit,
  output logic [BIDX_W-1:0] o_pred_bidx,
  input  logic              i_upd_vld,
  input  logic [XLEN-1:0]   i_upd_pc,
  input  logic [BIDX_W-1:0] i_upd_bidx,
  input  logic              i_upd_is_br,
  input  logic              i_upd_is_jmp,
  input  logic              i_upd_taken,
  input  logic [XLEN-1:0]   i_upd_target,
  input  logic              i_upd_pred_taken,
  input  logic [XLEN-1:0]   i_upd_pred_target,
  output logic              o_mispred,
  output logic [XLEN-1:0]   o_redirect_pc,
  output logic [31:0]       o_br_cnt,
  output logic [31:0]       o_mispred_cnt
);
  localparam int IDX_W   = $clog2(BTB_ENTRIES);
  localparam int GHR_LEN = (GHR_W > 0) ? GHR_W : 1;

  btb_entry_t        btb_q [BTB_ENTRIES];
  btb_entry_t        btb_d [BTB_ENTRIES];
  btb_entry_t        btb_rd;
  logic [GHR_LEN-1:0] ghr_q, ghr_d;
  logic [31:0]       br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [BIDX_W-1:0] ghr_ext;
  logic [CNT_W-1:0]  bht_cnt;
  logic [IDX_W-1:0]  lu_idx, upd_idx;
  logic [XLEN-1:0]   pc_if_plus4;
  logic              ctrl, train_br;

  assign lu_idx      = i_pc_if[IDX_W+1:2];
  assign upd_idx     = i_upd_pc[IDX_W+1:2];
  assign pc_if_plus4 = i_pc_if + XLEN'(4);
  assign ghr_ext     = (GHR_W > 0) ? BIDX_W'(ghr_q) : '0;
  assign o_pred_bidx = i_pc_if[BIDX_W+1:2] ^ ghr_ext;

  bht_table #(
    .ENTRIES (BHT_ENTRIES),
    .CNT_W   (CNT_W)
  ) u_bht (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rd_idx   (o_pred_bidx),
    .o_rd_cnt   (bht_cnt),
    .i_wr_en    (train_br),
    .i_wr_idx   (i_upd_bidx),
    .i_wr_taken (i_upd_taken)
  );

  always_comb begin
    btb_rd        = btb_q[lu_idx];
    o_pred_hit    = btb_rd.valid && (btb_rd.tag == BP_XLEN_MAX'(i_pc_if[XLEN-1:IDX_W+2]));
    o_pred_taken  = o_pred_hit && (btb_rd.is_jmp || bht_cnt[CNT_W-1]);
    o_pred_target = o_pred_taken ? XLEN'(btb_rd.target) : pc_if_plus4;
  end

  // A jump with is_br also set is treated purely as a jump.
  assign ctrl     = i_upd_vld && (i_upd_is_br || i_upd_is_jmp);
  assign train_br = ctrl && i_upd_is_br && !i_upd_is_jmp;

  assign o_mispred = ctrl && ((i_upd_taken != i_upd_pred_taken) ||
                              (i_upd_taken && (i_upd_target != i_upd_pred_target)));
  assign o_redirect_pc = !ctrl      ? '0 :
                         i_upd_taken ? i_upd_target : i_upd_pc + XLEN'(4);

  always_comb begin
    btb_d     = btb_q;
    ghr_d     = ghr_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (ctrl && i_upd_taken) begin
      btb_d[upd_idx] = '{valid:  1'b1,
                         tag:    BP_XLEN_MAX'(i_upd_pc[XLEN-1:IDX_W+2]),
                         target: BP_XLEN_MAX'(i_upd_target),
                         is_jmp: i_upd_is_jmp};
    end
    if (GHR_W > 0 && train_br) ghr_d = GHR_LEN'({ghr_q, i_upd_taken});
    if (ctrl && br_cnt_q != '1) br_cnt_d = br_cnt_q + 32'd1;
    if (o_mispred && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
      ghr_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      btb_q     <= btb_d;
      ghr_q     <= ghr_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mis_cnt_q;
endmodule
